packed_psum_unpack_acc: RTL

//  Consumer end of the dual-INT8 DSP packing path. Takes the 33-bit packed
//  DSP product P = (A*2^16 + B)*C, with A and B signed INT8 and C the shared
//  INT8 weight. Splits it into the two signed 16-bit products A*C and B*C,

---
 rtl/packed_psum_unpack_acc_pkg.sv | 24 ++
 rtl/packed_psum_unpack_acc_if.sv | 31 +++
 rtl/packed_prod_split.sv | 22 ++
 rtl/packed_psum_unpack_acc.sv | 106 ++++++++++
 4 files changed

// File: rtl/packed_psum_unpack_acc_pkg.sv
// Shared definitions for the dual-INT8 packed DSP product path.
// Field offsets here must agree with the mul/packing side.
package packed_psum_unpack_acc_pkg;

    localparam int unsigned P_W_DEF   = 33;
    localparam int unsigned ACC_W_DEF = 32;
    localparam int unsigned CNT_W_DEF = 16;

    localparam int unsigned LO_LSB = 0;
    localparam int unsigned HI_LSB = 16;
    localparam int unsigned PROD_W = 16;

    // Two signed 16-bit products recovered from one packed DSP result
    typedef struct packed {
        logic [PROD_W-1:0] hi;
        logic [PROD_W-1:0] lo;
    } prod_pair_t;

    // Signed add overflow from the operand and result sign bits
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/packed_psum_unpack_acc_if.sv
// Beat-in / window-result-out bus of the packed psum unpacker.
interface packed_psum_unpack_acc_if
    import packed_psum_unpack_acc_pkg::*;
#(
    parameter int unsigned P_W   = P_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [P_W-1:0]   in_p;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc_hi;
    logic [ACC_W-1:0] out_acc_lo;
    logic [CNT_W-1:0] out_beats;
    logic             out_ovf;

    modport master (
        output in_valid, in_p, in_last, out_ready,
        input  in_ready, out_valid, out_acc_hi, out_acc_lo, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_p, in_last, out_ready,
        output in_ready, out_valid, out_acc_hi, out_acc_lo, out_beats, out_ovf
    );

endinterface

// File: rtl/packed_prod_split.sv
// Splits a packed (A*2^16 + B)*C product into A*C and B*C.
// The low product's sign borrows one from the high field; add it back.
module packed_prod_split
    import packed_psum_unpack_acc_pkg::*;
#(
    parameter int unsigned P_W = P_W_DEF
) (
    input  logic [P_W-1:0] i_p,
    output prod_pair_t     o_prod
);

    logic [PROD_W-1:0] w_raw_hi;
    logic              w_borrow;
    logic              w_unused_msb;

    assign w_raw_hi     = i_p[HI_LSB +: PROD_W];
    assign w_borrow     = i_p[LO_LSB + PROD_W - 1];
    assign o_prod.lo    = i_p[LO_LSB +: PROD_W];
    assign o_prod.hi    = w_raw_hi + PROD_W'(w_borrow);
    assign w_unused_msb = ^i_p[P_W-1:HI_LSB+PROD_W];

endmodule

// File: rtl/packed_psum_unpack_acc.sv
// Unpacks dual-INT8 DSP products and accumulates both lanes per window.
// Two stages: registered split, then accumulate / emit on the last beat.
module packed_psum_unpack_acc
    import packed_psum_unpack_acc_pkg::*;
#(
    parameter int unsigned P_W   = P_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic                     clk,
    input logic                     rst,
    packed_psum_unpack_acc_if.slave i_bus
);

    prod_pair_t       w_split;
    logic             w_stall;
    logic             w_accept;
    logic [ACC_W-1:0] w_ext_hi;
    logic [ACC_W-1:0] w_ext_lo;
    logic [ACC_W-1:0] w_sum_hi;
    logic [ACC_W-1:0] w_sum_lo;
    logic [CNT_W-1:0] w_beats_nxt;
    logic             w_ovf_nxt;

    logic             r_s1_valid;
    logic             r_s1_last;
    prod_pair_t       r_s1;
    logic [ACC_W-1:0] r_acc_hi;
    logic [ACC_W-1:0] r_acc_lo;
    logic [CNT_W-1:0] r_beats;
    logic             r_ovf;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_hi;
    logic [ACC_W-1:0] r_out_lo;
    logic [CNT_W-1:0] r_out_beats;
    logic             r_out_ovf;

    packed_prod_split #(.P_W(P_W)) u_split (
        .i_p    (i_bus.in_p),
        .o_prod (w_split)
    );

    assign w_stall        = r_out_valid & ~i_bus.out_ready;
    assign w_accept       = i_bus.in_valid & i_bus.in_ready;
    assign i_bus.in_ready = ~rst & ~w_stall;

    // Sign-extend each lane to accumulator width and add
    assign w_ext_hi    = ACC_W'($signed(r_s1.hi));
    assign w_ext_lo    = ACC_W'($signed(r_s1.lo));
    assign w_sum_hi    = r_acc_hi + w_ext_hi;
    assign w_sum_lo    = r_acc_lo + w_ext_lo;
    assign w_beats_nxt = (&r_beats) ? r_beats : r_beats + CNT_W'(1);
    assign w_ovf_nxt   = r_ovf
                       | add_ovf(r_acc_hi[ACC_W-1], w_ext_hi[ACC_W-1], w_sum_hi[ACC_W-1])
                       | add_ovf(r_acc_lo[ACC_W-1], w_ext_lo[ACC_W-1], w_sum_lo[ACC_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1        <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_beats     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_hi    <= '0;
            r_out_lo    <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1      <= w_split;
                r_s1_last <= i_bus.in_last;
            end
            if (r_s1_valid && r_s1_last) begin
                r_out_valid <= 1'b1;
                r_out_hi    <= w_sum_hi;
                r_out_lo    <= w_sum_lo;
                r_out_beats <= w_beats_nxt;
                r_out_ovf   <= w_ovf_nxt;
                r_acc_hi    <= '0;
                r_acc_lo    <= '0;
                r_beats     <= '0;
                r_ovf       <= 1'b0;
            end else begin
                // Not stalled: any pending result has just been taken
                r_out_valid <= 1'b0;
                if (r_s1_valid) begin
                    r_acc_hi <= w_sum_hi;
                    r_acc_lo <= w_sum_lo;
                    r_beats  <= w_beats_nxt;
                    r_ovf    <= w_ovf_nxt;
                end
            end
        end
    end

    assign i_bus.out_valid  = r_out_valid;
    assign i_bus.out_acc_hi = r_out_hi;
    assign i_bus.out_acc_lo = r_out_lo;
    assign i_bus.out_beats  = r_out_beats;
    assign i_bus.out_ovf    = r_out_ovf;

endmodule
